// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter giving the I-cache and D-cache fill paths one line-sized
// memory transaction at a time. Define MEM_ARB_TIMEOUT_EN to add the WAIT watchdog.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 128
`ifdef MEM_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 64
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ic_req_valid,
    input  logic [ADDR_W-1:0] ic_req_addr,
    output logic              ic_resp_valid,
    output logic [LINE_W-1:0] ic_resp_data,
    input  logic              dc_req_valid,
    input  logic              dc_req_write,
    input  logic [ADDR_W-1:0] dc_req_addr,
    input  logic [LINE_W-1:0] dc_req_data,
    output logic              dc_resp_valid,
    output logic [LINE_W-1:0] dc_resp_data,
    output logic              resp_err,
    output logic              mem_req_valid,
    output logic              mem_req_write,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [LINE_W-1:0] mem_req_data,
    input  logic              mem_resp_valid,
    input  logic [LINE_W-1:0] mem_resp_data
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    state_t state, state_nx;
    logic last_d, owner_d, wr, grant_d, any_req, resp_hit, tmo, done;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] wdata, line;

    assign any_req  = ic_req_valid || dc_req_valid;
    // D wins when alone, or on a conflict when I held the last grant
    assign grant_d  = dc_req_valid && (!ic_req_valid || !last_d);
    assign resp_hit = mem_resp_valid && (state == ISSUE || state == WAIT);
    assign done     = resp_hit || tmo;
    assign line     = (resp_hit && !wr) ? mem_resp_data : '0;

    assign mem_req_valid = state == ISSUE;
    assign mem_req_write = wr;
    assign mem_req_addr  = addr;
    assign mem_req_data  = wdata;
    assign ic_resp_valid = state == RESP && !owner_d;
    assign dc_resp_valid = state == RESP && owner_d;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = any_req ? ISSUE : IDLE;
            ISSUE:   state_nx = resp_hit ? RESP : WAIT;
            WAIT:    state_nx = done ? RESP : WAIT;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            last_d       <= 1'b0;
            owner_d      <= 1'b0;
            wr           <= 1'b0;
            addr         <= '0;
            wdata        <= '0;
            ic_resp_data <= '0;
            dc_resp_data <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && any_req) begin
                owner_d <= grant_d;
                wr      <= grant_d && dc_req_write;
                addr    <= (grant_d ? dc_req_addr : ic_req_addr) & ~ADDR_W'(15);
                wdata   <= (grant_d && dc_req_write) ? dc_req_data : '0;
            end
            if (state == RESP) last_d <= owner_d;
            if (done && owner_d) dc_resp_data <= line;
            if (done && !owner_d) ic_resp_data <= line;
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] timer;
    logic err;
    assign tmo      = state == WAIT && !mem_resp_valid && timer == TW'(TIMEOUT_CYCLES - 1);
    assign resp_err = state == RESP && err;

    always_ff @(posedge clk) begin
        if (reset) begin
            timer <= '0;
            err   <= 1'b0;
        end else begin
            timer <= state == WAIT ? timer + 1'b1 : '0;
            if (state == ISSUE || state == WAIT) err <= tmo;
        end
    end
`else
    assign tmo      = 1'b0;
    assign resp_err = 1'b0;
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with a fixed-latency memory model.
// Inputs and checks happen on the falling edge; the memory answers 10 cycles after its request.
module tb_mem_arbiter;
    logic         clk = 1'b0;
    logic         reset;
    logic         ic_req_valid, dc_req_valid, dc_req_write;
    logic [31:0]  ic_req_addr, dc_req_addr;
    logic [127:0] dc_req_data;
    logic         ic_resp_valid, dc_resp_valid, resp_err;
    logic [127:0] ic_resp_data, dc_resp_data;
    logic         mem_req_valid, mem_req_write, mem_resp_valid;
    logic [31:0]  mem_req_addr;
    logic [127:0] mem_req_data, mem_resp_data;

    logic         mem_auto = 1'b1;
    logic [127:0] mem_line = '0;
    logic         q_write;
    logic [31:0]  q_addr;
    logic [127:0] q_data;
    int total = 0, bad = 0;
    int c, rc;
    logic gi, gd, er;

    localparam logic [127:0] LA = {32{4'hA}};
    localparam logic [127:0] L5 = {32{4'h5}};
    localparam logic [127:0] LC = {32{4'hC}};
    localparam logic [127:0] LF = {32{4'hF}};
    localparam logic [127:0] L3 = {32{4'h3}};
    localparam logic [127:0] WD = {4{32'h12345678}};

    always #5 clk = ~clk;

`ifdef MEM_ARB_TIMEOUT_EN
    mem_arbiter #(.TIMEOUT_CYCLES(64)) dut (
`else
    mem_arbiter dut (
`endif
        .clk(clk), .reset(reset),
        .ic_req_valid(ic_req_valid), .ic_req_addr(ic_req_addr),
        .ic_resp_valid(ic_resp_valid), .ic_resp_data(ic_resp_data),
        .dc_req_valid(dc_req_valid), .dc_req_write(dc_req_write),
        .dc_req_addr(dc_req_addr), .dc_req_data(dc_req_data),
        .dc_resp_valid(dc_resp_valid), .dc_resp_data(dc_resp_data),
        .resp_err(resp_err),
        .mem_req_valid(mem_req_valid), .mem_req_write(mem_req_write),
        .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
    );

    // Memory: request seen in cycle k, completion pulse driven through cycle k+10
    initial begin
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        forever begin
            @(negedge clk);
            if (mem_req_valid && mem_auto) begin
                repeat (10) @(posedge clk);
                #1;
                mem_resp_valid = 1'b1;
                mem_resp_data  = mem_line;
                @(posedge clk);
                #1;
                mem_resp_valid = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Counts falling edges until a resp pulse; notes when and what was sent to memory
    task automatic wait_resp(output int cyc, output int req_cyc, output logic got_i,
                             output logic got_d, output logic err);
        cyc = 0; req_cyc = 0; got_i = 0; got_d = 0; err = 0;
        while (cyc < 100 && !got_i && !got_d) begin
            @(negedge clk);
            cyc++;
            if (mem_req_valid && req_cyc == 0) begin
                req_cyc = cyc;
                q_write = mem_req_write;
                q_addr  = mem_req_addr;
                q_data  = mem_req_data;
            end
            got_i = ic_resp_valid;
            got_d = dc_resp_valid;
            err   = resp_err;
        end
    endtask

    initial begin
        reset = 1'b1;
        ic_req_valid = 0; dc_req_valid = 0; dc_req_write = 0;
        ic_req_addr = '0; dc_req_addr = '0; dc_req_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_outs", {ic_resp_valid, dc_resp_valid, resp_err, mem_req_valid, mem_req_write}, '0);
        chk("rst_ic_data", ic_resp_data, '0);
        chk("rst_dc_data", dc_resp_data, '0);
        chk("rst_mem_addr", mem_req_addr, '0);
        chk("rst_mem_data", mem_req_data, '0);

        // I alone
        reset = 1'b0;
        mem_line = LA;
        ic_req_valid = 1; ic_req_addr = 32'h1004;
        wait_resp(c, rc, gi, gd, er);
        ic_req_valid = 0;
        chk("i_req_cyc", rc, 1);
        chk("i_req_addr", q_addr, 32'h1000);
        chk("i_req_write", q_write, 0);
        chk("i_resp_cyc", c, 12);
        chk("i_resp_who", {gi, gd}, 2'b10);
        chk("i_resp_data", ic_resp_data, LA);
        chk("i_resp_err", er, 0);
        @(negedge clk);
        chk("i_pulse_end", {ic_resp_valid, dc_resp_valid}, 0);

        // Conflict: D first, I one IDLE cycle later
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        mem_line = L5;
        ic_req_valid = 1; ic_req_addr = 32'h1100;
        dc_req_valid = 1; dc_req_write = 0; dc_req_addr = 32'h2008;
        wait_resp(c, rc, gi, gd, er);
        dc_req_valid = 0;
        mem_line = LC;
        chk("c1_who", {gi, gd}, 2'b01);
        chk("c1_cyc", c, 12);
        chk("c1_addr", q_addr, 32'h2000);
        chk("c1_data", dc_resp_data, L5);
        wait_resp(c, rc, gi, gd, er);
        ic_req_valid = 0;
        chk("c2_who", {gi, gd}, 2'b10);
        chk("c2_req_cyc", rc, 2);
        chk("c2_cyc", c, 13);
        chk("c2_addr", q_addr, 32'h1100);
        chk("c2_data", ic_resp_data, LC);
        chk("c2_dc_hold", dc_resp_data, L5);

        // D writeback: ack data is not forwarded
        mem_line = LF;
        dc_req_valid = 1; dc_req_write = 1; dc_req_addr = 32'h4010; dc_req_data = WD;
        wait_resp(c, rc, gi, gd, er);
        dc_req_valid = 0; dc_req_write = 0;
        chk("wb_write", q_write, 1);
        chk("wb_addr", q_addr, 32'h4010);
        chk("wb_wdata", q_data, WD);
        chk("wb_who", {gi, gd}, 2'b01);
        chk("wb_err", er, 0);
        chk("wb_rdata", dc_resp_data, '0);
        chk("wb_ic_hold", ic_resp_data, LC);

        // Both requesting back to back: D, I, D, I
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        ic_req_valid = 1; ic_req_addr = 32'h5000;
        dc_req_valid = 1; dc_req_addr = 32'h6000;
        for (int k = 0; k < 4; k++) begin
            wait_resp(c, rc, gi, gd, er);
            chk($sformatf("rr%0d_who", k), {gi, gd}, (k % 2 == 0) ? 2'b01 : 2'b10);
            chk($sformatf("rr%0d_cyc", k), c, (k == 0) ? 12 : 11);
            if (gd) dc_req_valid = 0;
            if (gi) ic_req_valid = 0;
            @(negedge clk);
            @(negedge clk);
            if (k < 2 && gd) dc_req_valid = 1;
            if (k < 2 && gi) ic_req_valid = 1;
        end
        chk("rr_idle_req", mem_req_valid, 0);

        // Reset during WAIT; the stale completion lands in IDLE
        ic_req_valid = 1; ic_req_addr = 32'h7000;
        repeat (8) @(negedge clk);
        chk("rw_in_wait", {ic_resp_valid, mem_req_valid}, 0);
        reset = 1'b1; ic_req_valid = 0;
        @(negedge clk);
        reset = 1'b0;
        chk("rw_rst_outs", {ic_resp_valid, dc_resp_valid, resp_err, mem_req_valid, mem_req_write}, 0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk($sformatf("rw_quiet%0d", k), {ic_resp_valid, dc_resp_valid, mem_req_valid}, 0);
        end
        mem_line = L3;
        dc_req_valid = 1; dc_req_addr = 32'h300F;
        wait_resp(c, rc, gi, gd, er);
        dc_req_valid = 0;
        chk("rw_next_who", {gi, gd}, 2'b01);
        chk("rw_next_cyc", c, 12);
        chk("rw_next_addr", q_addr, 32'h3000);
        chk("rw_next_data", dc_resp_data, L3);

`ifdef MEM_ARB_TIMEOUT_EN
        // Silent memory: RESP after ISSUE plus 64 WAIT cycles
        @(negedge clk);
        mem_auto = 0;
        ic_req_valid = 1; ic_req_addr = 32'h8000;
        wait_resp(c, rc, gi, gd, er);
        ic_req_valid = 0;
        chk("to_cyc", c, 66);
        chk("to_who", {gi, gd}, 2'b10);
        chk("to_err", er, 1);
        chk("to_data", ic_resp_data, '0);
        @(negedge clk);
        chk("to_idle", {ic_resp_valid, resp_err, mem_req_valid}, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
